// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone memory arbiter: FSM state encoding and
// arbitration mode selectors.
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant picker: round-robin starting after the last
// owner, or fixed priority with the lowest index winning.
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MODE        = ARB_RR,
    parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (MODE == ARB_FIXED) begin
                idx = PTR_W'(k);
            end else begin
                idx = PTR_W'((int'(ptr) + 1 + k) % NUM_MASTERS);
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with cycle locking, per-master
// ack/err routing and an ack-timeout watchdog.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       gnt_idx;
    logic [CNT_W-1:0]       wd_cnt;
    logic                   busy;
    logic                   owner_cyc;
    logic                   timeout_hit;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .MODE        (PRIORITY_MODE),
        .PTR_W       (PTR_W)
    ) u_arb (
        .req (m_cyc_i),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign busy      = (state == ST_BUSY);
    assign owner_cyc = |(m_cyc_i & grant);

    // Slave cycle drops in the same cycle the owner releases, before the FSM catches up.
    assign s_cyc_o = busy & owner_cyc;
    assign s_stb_o = s_cyc_o & |(m_stb_i & grant);
    assign s_we_o  = busy & |(m_we_i & grant);

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        if (busy) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant[i]) begin
                    s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant & {NUM_MASTERS{busy & s_ack_i}};
    assign m_err_o = grant & {NUM_MASTERS{state == ST_ERR}};
    assign grant_o = grant;

    // An ack on the limit cycle suppresses the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && s_stb_o && !s_ack_i && (wd_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            grant  <= '0;
            ptr    <= PTR_W'(NUM_MASTERS - 1);
            wd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (|m_cyc_i) begin
                        grant <= arb_gnt;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_cyc) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        ptr    <= gnt_idx;
                        wd_cnt <= '0;
                    end else if (timeout_hit) begin
                        state  <= ST_ERR;
                        wd_cnt <= '0;
                    end else if (s_stb_o && !s_ack_i) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ST_ERR: begin
                    wd_cnt <= '0;
                    if (owner_cyc) begin
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                        grant <= '0;
                        ptr   <= gnt_idx;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    grant  <= '0;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a round-robin and a fixed-priority instance share
// directed stimulus and are checked against an ownership-level reference model.
module tb_wb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0] s_dat_i;
    logic          s_ack;

    logic [DW-1:0] r_mdat, f_mdat, r_sdat, f_sdat;
    logic [AW-1:0] r_adr, f_adr;
    logic [N-1:0]  r_ack, f_ack, r_err, f_err, r_gnt, f_gnt;
    logic          r_cyc, f_cyc, r_stb, f_stb, r_we, f_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .rst(rst), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(r_mdat), .m_ack_o(r_ack),
        .m_err_o(r_err), .s_cyc_o(r_cyc), .s_stb_o(r_stb), .s_we_o(r_we),
        .s_adr_o(r_adr), .s_dat_o(r_sdat), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .grant_o(r_gnt));

    wb_mem_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) dut_fx (
        .clk(clk), .rst(rst), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(f_mdat), .m_ack_o(f_ack),
        .m_err_o(f_err), .s_cyc_o(f_cyc), .s_stb_o(f_stb), .s_we_o(f_we),
        .s_adr_o(f_adr), .s_dat_o(f_sdat), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .grant_o(f_gnt));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // Reference model: which master owns the port (-1 = nobody), whether the
    // owner is serving its one error cycle, last owner, and stalled-strobe count.
    int owner[2];
    int last[2];
    int stall[2];
    bit in_err[2];

    task automatic model_next(input int d, output int o, output int p, output int c, output bit e);
        o = owner[d]; p = last[d]; c = stall[d]; e = in_err[d];
        if (o < 0) begin
            c = 0;
            if (m_cyc != '0) begin
                if (d == 1) begin
                    for (int i = N - 1; i >= 0; i--) if (bit_of(m_cyc, i)) o = i;
                end else begin
                    for (int k = N; k >= 1; k--) if (bit_of(m_cyc, (p + k) % N)) o = (p + k) % N;
                end
            end
        end else if (e) begin
            e = 1'b0;
            c = 0;
            if (!bit_of(m_cyc, o)) begin p = o; o = -1; end
        end else if (!bit_of(m_cyc, o)) begin
            p = o; o = -1; c = 0;
        end else if (bit_of(m_stb, o) && !s_ack) begin
            c = c + 1;
            if (c == TO) begin e = 1'b1; c = 0; end
        end else begin
            c = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        int o, p, c;
        bit e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                owner[d] <= -1; last[d] <= N - 1; stall[d] <= 0; in_err[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                model_next(d, o, p, c, e);
                owner[d] <= o; last[d] <= p; stall[d] <= c; in_err[d] <= e;
            end
        end
    end

    task automatic cmp_dut(input int d, input logic [N-1:0] gnt, input logic [N-1:0] ack,
                           input logic [N-1:0] err, input logic cyc, input logic stb,
                           input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] sdat, input logic [DW-1:0] mdat);
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        int o;
        bit serving;
        string tag;
        tag = (d == 0) ? "rr" : "fx";
        o = owner[d];
        serving = (o >= 0) && !in_err[d];
        e_gnt = (o >= 0) ? (N'(1) << o) : '0;
        e_ack = (serving && s_ack) ? e_gnt : '0;
        e_err = (o >= 0 && in_err[d]) ? e_gnt : '0;
        e_cyc = serving && bit_of(m_cyc, o);
        e_stb = e_cyc && bit_of(m_stb, o);
        e_we  = serving && bit_of(m_we, o);
        e_adr = '0;
        e_dat = '0;
        if (serving) begin
            e_adr = m_adr[o*AW +: AW];
            e_dat = m_dat[o*DW +: DW];
        end
        chk({tag, ".grant"}, gnt, e_gnt);
        chk({tag, ".m_ack"}, ack, e_ack);
        chk({tag, ".m_err"}, err, e_err);
        chk({tag, ".s_cyc"}, cyc, e_cyc);
        chk({tag, ".s_stb"}, stb, e_stb);
        chk({tag, ".s_we"}, we, e_we);
        chk({tag, ".s_adr"}, adr, e_adr);
        chk({tag, ".s_dat"}, sdat, e_dat);
        chk({tag, ".m_dat"}, mdat, s_dat_i);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, r_gnt, r_ack, r_err, r_cyc, r_stb, r_we, r_adr, r_sdat, r_mdat);
        cmp_dut(1, f_gnt, f_ack, f_err, f_cyc, f_stb, f_we, f_adr, f_sdat, f_mdat);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int acks1, acks0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        s_dat_i = '0; s_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.grant", r_gnt, 2'b00);
        chk("reset.s_cyc", r_cyc, 1'b0);
        chk("reset.s_adr", r_adr, 32'h0);
        rst = 1'b1;
        s_dat_i = 32'hCAFE_0001;

        // Contention from reset: rr alternates 01,10,01, fx keeps master 0.
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr = {32'h0000_0200, 32'h0000_0100};
        #1 chk("A.idle_before_edge", r_gnt, 2'b00);
        tick();
        chk("A.rr.grant1", r_gnt, 2'b01);
        chk("A.fx.grant1", f_gnt, 2'b01);
        chk("A.s_adr", r_adr, 32'h100);
        s_ack = 1'b1;
        #1 chk("A.rr.ack1", r_ack, 2'b01);
        tick();
        s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
        #1 chk("A.rr.cyc_drop", r_cyc, 1'b0);
        tick();
        chk("A.rr.idle_gap", r_gnt, 2'b00);
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        chk("A.rr.grant2", r_gnt, 2'b10);
        chk("A.fx.grant2", f_gnt, 2'b01);
        s_ack = 1'b1; s_dat_i = 32'h1234_5678;
        #1;
        chk("A.rr.ack2", r_ack, 2'b10);
        chk("A.fx.ack2", f_ack, 2'b01);
        chk("A.m_dat", r_mdat, 32'h1234_5678);
        tick();
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        chk("A.rr.idle2", r_gnt, 2'b00);
        chk("A.fx.locked", f_gnt, 2'b01);
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        chk("A.rr.grant3", r_gnt, 2'b01);
        chk("A.fx.m1_waits", f_gnt, 2'b01);
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        chk("F.fx.idle", f_gnt, 2'b00);
        tick();
        chk("F.fx.m1_after_release", f_gnt, 2'b10);
        chk("F.rr.m1", r_gnt, 2'b10);
        m_cyc = '0; m_stb = '0;
        repeat (2) tick();

        // Single master 1 write, acked on its third cycle.
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
        m_adr[63:32] = 32'h10;
        m_dat = {32'hDEAD_BEEF, 32'h1111_1111};
        tick();
        chk("B.grant", r_gnt, 2'b10);
        chk("B.s_adr", r_adr, 32'h10);
        chk("B.s_dat", r_sdat, 32'hDEAD_BEEF);
        chk("B.s_we", r_we, 1'b1);
        tick();
        chk("B.no_ack_yet", r_ack, 2'b00);
        tick();
        s_ack = 1'b1;
        #1 chk("B.ack", r_ack, 2'b10);
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        #1 chk("B.cyc_drop", r_cyc, 1'b0);
        tick();
        chk("B.idle", r_gnt, 2'b00);

        // Locked burst by master 1 while master 0 requests.
        m_cyc = 2'b10; m_stb = 2'b10; m_adr[63:32] = 32'h0;
        tick();
        chk("C.fx.grant", f_gnt, 2'b10);
        m_cyc = 2'b11; m_stb = 2'b11; m_adr[31:0] = 32'h500;
        acks1 = 0; acks0 = 0;
        for (int i = 0; i < 4; i++) begin
            m_adr[63:32] = 32'(i * 4);
            s_ack = 1'b1;
            #1;
            chk("C.s_adr", r_adr, 32'(i * 4));
            chk("C.rr.grant", r_gnt, 2'b10);
            if (r_ack == 2'b10) acks1++;
            if (r_ack[0]) acks0++;
            tick();
        end
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
        chk("C.acks_m1", acks1, 4);
        chk("C.acks_m0", acks0, 0);
        tick();
        chk("C.idle", r_gnt, 2'b00);
        tick();
        chk("C.rr.m0_after", r_gnt, 2'b01);
        chk("C.fx.m0_after", f_gnt, 2'b01);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        repeat (2) tick();

        // Watchdog: no ack for 8 strobe cycles.
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h40;
        tick();
        chk("D.grant", r_gnt, 2'b01);
        repeat (7) tick();
        chk("D.no_err_yet", r_err, 2'b00);
        chk("D.cyc_before", r_cyc, 1'b1);
        tick();
        chk("D.rr.err", r_err, 2'b01);
        chk("D.fx.err", f_err, 2'b01);
        chk("D.cyc_in_err", r_cyc, 1'b0);
        chk("D.stb_in_err", r_stb, 1'b0);
        tick();
        chk("D.err_pulse_end", r_err, 2'b00);
        chk("D.cyc_back", r_cyc, 1'b1);
        repeat (7) tick();
        chk("D.counter_cleared", r_err, 2'b00);
        tick();
        chk("D.err_again", r_err, 2'b01);
        m_cyc = '0; m_stb = '0;
        tick();
        chk("D.err_to_idle", r_gnt, 2'b00);
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        repeat (7) tick();
        s_ack = 1'b1;
        #1 chk("D.ack_on_limit", r_ack, 2'b01);
        tick();
        s_ack = 1'b0;
        chk("D.ack_wins", r_err, 2'b00);
        chk("D.still_busy", r_cyc, 1'b1);
        m_cyc = '0; m_stb = '0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a transfer.
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr[63:32] = 32'h80;
        tick();
        chk("E.grant", r_gnt, 2'b10);
        s_ack = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("E.grant_rst", r_gnt, 2'b00);
        chk("E.cyc_rst", r_cyc, 1'b0);
        chk("E.stb_rst", r_stb, 1'b0);
        chk("E.we_rst", r_we, 1'b0);
        chk("E.adr_rst", r_adr, 32'h0);
        chk("E.ack_rst", r_ack, 2'b00);
        m_cyc = 2'b11; m_stb = 2'b11; m_we = '0; s_ack = 1'b0;
        tick();
        #2 rst = 1'b1;
        tick();
        chk("E.rr.m0_first", r_gnt, 2'b01);
        chk("E.fx.m0_first", f_gnt, 2'b01);
        m_cyc = '0; m_stb = '0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
